// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants, channel id type and the select/data
//                consistency check for the 1-to-4 demux bit collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef logic [CH_W-1:0] chan_t;

   // A beat is consistent when no demux output other than the selected one is high.
   function automatic logic onehot_ok(input chan_t sel, input logic [NUM_CH-1:0] y);
      logic [NUM_CH-1:0] w_sel_mask;
      logic [NUM_CH-1:0] w_others;
      w_sel_mask = {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
      w_others   = y & ~w_sel_mask;
      return (w_others == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/demux_chan_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : demux_chan_shifter
//  Description : Per-channel MSB-first bit assembler. Shifts one bit per
//                enabled beat and pulses done on the beat completing a word,
//                presenting the completed word combinationally on that beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             flush,
   input  logic             bit_in,
   output logic             done,
   output logic [WIDTH-1:0] word
);

   localparam int                CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  c_last = CNT_W'(WIDTH - 1);

   // The newest bit of the WIDTH-bit register is always the incoming bit, so
   // only the WIDTH-1 older bits need storage.
   logic [WIDTH-2:0] r_sr;
   logic [CNT_W-1:0] r_cnt;

   assign done = shift_en && (r_cnt == c_last);
   assign word = {r_sr, bit_in};

   // Shift in the routed bit and count it; wrap the count when a word completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (shift_en) begin
         r_sr  <= word[WIDTH-2:0];
         r_cnt <= done ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/demux_bit_collector.sv
`default_nettype none
// ============================================================================
//  Module      : demux_bit_collector
//  Description : Collects bits routed by a 1-to-4 demux into per-channel
//                words, emits completed words tagged with their channel over
//                a valid/ready interface and flags inconsistent demux beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_bit_collector
   import demux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [1:0]        in_sel,
   input  logic [NUM_CH-1:0] in_y,
   output logic              in_ready,
   input  logic              flush,
   output logic              out_valid,
   output logic [1:0]        out_chan,
   output logic [WIDTH-1:0]  out_data,
   input  logic              out_ready,
   output logic              err,
   input  logic              err_clr
);

   logic              w_accept;
   logic              w_consistent;
   logic              w_bit;
   logic              w_any_done;
   logic [NUM_CH-1:0] w_shift_en;
   logic [NUM_CH-1:0] w_done;
   logic [WIDTH-1:0]  w_word [NUM_CH];

   // A pending word that cannot drain stalls every channel, not just the one
   // about to complete, which keeps the output register single-entry.
   assign in_ready     = !flush && (!out_valid || out_ready);
   assign w_accept     = in_valid && in_ready;
   assign w_consistent = onehot_ok(chan_t'(in_sel), in_y);
   assign w_bit        = in_y[in_sel];
   assign w_any_done   = |w_done;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
         assign w_shift_en[g] = w_accept && w_consistent && (in_sel == chan_t'(g));

         demux_chan_shifter #(
            .WIDTH    (WIDTH)
         ) u_shifter (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (w_shift_en[g]),
            .flush    (flush),
            .bit_in   (w_bit),
            .done     (w_done[g]),
            .word     (w_word[g])
         );
      end
   endgenerate

   // Output holding register: a completion reloads it (even while draining),
   // otherwise a taken word empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_chan  <= '0;
         out_data  <= '0;
      end else if (w_any_done) begin
         out_valid <= 1'b1;
         out_chan  <= in_sel;
         out_data  <= w_word[in_sel];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky inconsistency flag; a new inconsistency beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (w_accept && !w_consistent) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_demux_bit_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_bit_collector
//  Description : Self-checking bench for demux_bit_collector with a
//                word-level reference model and a queue-based scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_demux_bit_collector;

   localparam int WIDTH = 8;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic [1:0]       in_sel    = 2'd0;
   logic [3:0]       in_y      = 4'd0;
   logic             flush     = 1'b0;
   logic             out_ready = 1'b0;
   logic             err_clr   = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [1:0]       out_chan;
   logic [WIDTH-1:0] out_data;
   logic             err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit               m_occ;
   bit               m_err;
   logic [WIDTH-1:0] m_acc [4];
   int               m_n   [4];
   logic [9:0]       exp_q [$];
   bit               mon_en = 1'b0;

   demux_bit_collector #(.WIDTH(WIDTH), .NUM_CH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sel    (in_sel),
      .in_y      (in_y),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_chan  (out_chan),
      .out_data  (out_data),
      .out_ready (out_ready),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_occ = 1'b0;
      m_err = 1'b0;
      for (int c = 0; c < 4; c++) begin
         m_acc[c] = '0;
         m_n[c]   = 0;
      end
      exp_q.delete();
   endtask

   // One clock of stimulus: drive at negedge, check in_ready, update the model at posedge.
   task automatic step(input bit v, input bit [1:0] s, input bit [3:0] y,
                       input bit fl, input bit ordy, input bit ec);
      bit               exp_rdy;
      bit               acc;
      bit               cons;
      bit               done;
      logic [WIDTH-1:0] word;
      int               si;
      @(negedge clk);
      in_valid  = v;
      in_sel    = s;
      in_y      = y;
      flush     = fl;
      out_ready = ordy;
      err_clr   = ec;
      #1;
      exp_rdy = !fl && (!m_occ || ordy);
      chk("in_ready", in_ready, exp_rdy);
      si   = int'(s);
      acc  = v && exp_rdy;
      cons = (($countones(y) - int'(y[s])) == 0);
      done = 1'b0;
      word = '0;
      if (fl) begin
         for (int c = 0; c < 4; c++) begin
            m_acc[c] = '0;
            m_n[c]   = 0;
         end
      end
      if (acc && cons) begin
         m_acc[si] = (m_acc[si] << 1) | WIDTH'(y[s]);
         m_n[si]   = m_n[si] + 1;
         if (m_n[si] == WIDTH) begin
            done      = 1'b1;
            word      = m_acc[si];
            m_acc[si] = '0;
            m_n[si]   = 0;
         end
      end
      @(posedge clk);
      if (done) exp_q.push_back({s, word});
      m_occ = done ? 1'b1 : (ordy ? 1'b0 : m_occ);
      m_err = (acc && !cons) ? 1'b1 : (ec ? 1'b0 : m_err);
   endtask

   task automatic beat(input bit [1:0] s, input bit b, input bit ordy);
      step(1'b1, s, b ? (4'b0001 << s) : 4'b0000, 1'b0, ordy, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic send_word(input bit [1:0] s, input logic [WIDTH-1:0] w, input bit ordy);
      for (int i = WIDTH - 1; i >= 0; i--) beat(s, w[i], ordy);
   endtask

   // Scoreboard monitor: compares presented words against the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && rst_n) begin
            chk("out_valid", out_valid, m_occ);
            chk("err", err, m_err);
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: chan %0d data %0h with empty scoreboard", out_chan, out_data);
               end else begin
                  chk("out_chan", out_chan, exp_q[0][9:8]);
                  chk("out_data", out_data, exp_q[0][7:0]);
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      model_clear();
      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_data", out_data, 8'h00);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      idle(5);

      // Single channel: ch2 word 0xB2
      send_word(2'd2, 8'hB2, 1'b1);
      #3;
      chk("b2_valid", out_valid, 1'b1);
      chk("b2_chan", out_chan, 2'd2);
      chk("b2_data", out_data, 8'hB2);
      idle(3);

      // Interleaved back-to-back: ch0 all ones, ch3 all zeros
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) step(1'b1, 2'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
         else            step(1'b1, 2'd3, 4'b0000, 1'b0, 1'b1, 1'b0);
      end
      idle(3);

      // Backpressure on ch1 word 0x5A
      send_word(2'd1, 8'h5A, 1'b0);
      #3;
      chk("bp_data", out_data, 8'h5A);
      step(1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b0);
      #3;
      chk("bp_hold_data", out_data, 8'h5A);
      step(1'b1, 2'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
      idle(3);

      // Error: inconsistent beat on ch1 is discarded
      step(1'b1, 2'd1, 4'b0101, 1'b0, 1'b1, 1'b0);
      #3;
      chk("err_set", err, 1'b1);
      send_word(2'd1, 8'hC3, 1'b1);
      idle(2);
      step(1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      #3;
      chk("err_cleared", err, 1'b0);
      // set wins over clear
      step(1'b1, 2'd2, 4'b1100, 1'b0, 1'b1, 1'b1);
      step(1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      idle(2);

      // Flush discards a partial word on ch3
      for (int i = 0; i < 5; i++) beat(2'd3, 1'b1, 1'b1);
      step(1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 1'b0);
      send_word(2'd3, 8'h3C, 1'b1);
      idle(3);

      // Asynchronous reset mid-cycle with a word pending
      for (int i = 0; i < 5; i++) beat(2'd3, 1'b1, 1'b0);
      send_word(2'd0, 8'h81, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      #1;
      rst_n = 1'b1;
      send_word(2'd3, 8'h96, 1'b1);
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit [1:0] s;
         bit [3:0] y;
         bit       b;
         s = 2'($urandom_range(0, 3));
         b = 1'($urandom);
         if ($urandom_range(0, 99) < 8) y = 4'($urandom) | (4'b0001 << ((s + 2'd1) & 2'd3));
         else                           y = b ? (4'b0001 << s) : 4'b0000;
         step($urandom_range(0, 99) < 80, s, y,
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 75,
              $urandom_range(0, 99) < 5);
      end
      idle(4);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
